// File: rtl/mac_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_operand_sequencer
// Purpose  : Initiator side of the MAC operand interface. Buffers two 8-bit
//            operand vectors (A and B), then streams element pairs into a
//            registered multiply-accumulate unit, captures the final
//            accumulator value and signals completion with a done pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk      in   1     clock, rising edge
//   rst      in   1     asynchronous active-high reset
//   wr_en    in   1     buffer write strobe (honoured only while idle)
//   wr_sel   in   1     0 = buffer A, 1 = buffer B
//   wr_addr  in   AW    buffer write address
//   wr_data  in   8     buffer write data
//   len      in   AW+1  pair count, sampled with start (clamped to DEPTH)
//   start    in   1     launch a dot-product run
//   busy     out  1     run in progress (accepted start .. done cycle)
//   done     out  1     one-cycle completion pulse
//   result   out  ACCW  captured accumulator value, held until next run
//   mac_clr  out  1     MAC accumulator clear strobe
//   mac_vld  out  1     MAC operand-valid strobe
//   mac_a    out  8     operand A to MAC
//   mac_b    out  8     operand B to MAC
//   mac_acc  in   ACCW  registered accumulator value from the MAC
// ============================================================================
module mac_operand_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int ACCW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [AW-1:0]   wr_addr,
  input  logic [7:0]      wr_data,
  input  logic [AW:0]     len,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [ACCW-1:0] result,
  output logic            mac_clr,
  output logic            mac_vld,
  output logic [7:0]      mac_a,
  output logic [7:0]      mac_b,
  input  logic [ACCW-1:0] mac_acc
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]      state_q, state_d;
  logic [AW:0]     len_q,   len_d;     // clamped pair count for this run
  logic [AW:0]     idx_q,   idx_d;     // index of the next element to load
  logic [ACCW-1:0] result_q, result_d;
  logic [7:0]      mac_a_q, mac_a_d;
  logic [7:0]      mac_b_q, mac_b_d;
  logic [7:0]      buf_a_q [DEPTH];
  logic [7:0]      buf_a_d [DEPTH];
  logic [7:0]      buf_b_q [DEPTH];
  logic [7:0]      buf_b_d [DEPTH];

  // --------------------------------------------------------------------------
  // FSM process 1: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // A zero-length run skips the MAC entirely.
          state_d = (len == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR:  state_d = S_STREAM;
      S_STREAM: begin
        // idx_q runs one ahead of the pair on the bus, so reaching len_q
        // means the last pair is being presented this cycle.
        if (idx_q == len_q) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM process 3: output decode. All strobes come straight from the state
  // register, so they drop the instant an asynchronous reset arrives.
  // --------------------------------------------------------------------------
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    mac_clr = (state_q == S_CLEAR);
    mac_vld = (state_q == S_STREAM);
  end

  assign mac_a  = mac_a_q;
  assign mac_b  = mac_b_q;
  assign result = result_q;

  // --------------------------------------------------------------------------
  // Datapath next-value logic
  // --------------------------------------------------------------------------
  always_comb begin
    len_d    = len_q;
    idx_d    = idx_q;
    result_d = result_q;
    mac_a_d  = 8'h00;   // operands return to zero outside STREAM
    mac_b_d  = 8'h00;
    buf_a_d  = buf_a_q;
    buf_b_d  = buf_b_q;

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (wr_en) begin
          if (wr_sel) begin
            buf_b_d[wr_addr] = wr_data;
          end else begin
            buf_a_d[wr_addr] = wr_data;
          end
        end
        if (start) begin
          if (len == '0) begin
            result_d = '0;
          end else begin
            len_d = (len > DEPTH_C) ? DEPTH_C : len;
          end
        end
      end

      S_CLEAR: begin
        // Preload pair 0 so it is on the bus together with the first mac_vld.
        mac_a_d = buf_a_q[0];
        mac_b_d = buf_b_q[0];
        idx_d   = ONE_C;
      end

      S_STREAM: begin
        if (idx_q != len_q) begin
          mac_a_d = buf_a_q[idx_q[AW-1:0]];
          mac_b_d = buf_b_q[idx_q[AW-1:0]];
          idx_d   = idx_q + ONE_C;
        end
      end

      S_WAIT: begin
        // The last product was accumulated on the edge entering WAIT.
        result_d = mac_acc;
      end

      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      mac_a_q  <= '0;
      mac_b_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_a_q[i] <= '0;
        buf_b_q[i] <= '0;
      end
    end else begin
      len_q    <= len_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      mac_a_q  <= mac_a_d;
      mac_b_q  <= mac_b_d;
      for (int i = 0; i < DEPTH; i++) begin
        buf_a_q[i] <= buf_a_d[i];
        buf_b_q[i] <= buf_b_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_operand_sequencer
// Purpose  : Self-checking bench for mac_operand_sequencer. Drives directed
//            and random runs, emulates the registered MAC, and compares
//            every cycle of each run with the expected strobe/operand
//            pattern and the expected dot product.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_operand_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int ACCW  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic            wr_sel = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [7:0]      wr_data = '0;
  logic [AW:0]     len = '0;
  logic            start = 1'b0;
  logic            busy, done, mac_clr, mac_vld;
  logic [ACCW-1:0] result;
  logic [7:0]      mac_a, mac_b;
  logic [ACCW-1:0] mac_acc;

  int total = 0;
  int bad   = 0;

  // Model of the operand buffers as the host has written them.
  logic [7:0] ma [DEPTH];
  logic [7:0] mb [DEPTH];

  mac_operand_sequencer #(.DEPTH(DEPTH), .AW(AW), .ACCW(ACCW)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .len     (len),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .mac_clr (mac_clr),
    .mac_vld (mac_vld),
    .mac_a   (mac_a),
    .mac_b   (mac_b),
    .mac_acc (mac_acc)
  );

  always #5 clk = ~clk;

  // Registered MAC unit the sequencer talks to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mac_acc <= '0;
    else if (mac_clr) mac_acc <= '0;
    else if (mac_vld) mac_acc <= mac_acc + 16'(mac_a * mac_b);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic wr(input bit sel, input int addr, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (sel) mb[addr] = data; else ma[addr] = data;
  endtask

  // Expected dot product of the first n pairs, wrapped to ACCW bits.
  function automatic logic [ACCW-1:0] dot(input logic [7:0] a[DEPTH], input logic [7:0] b[DEPTH], input int n);
    int unsigned s = 0;
    for (int i = 0; i < n; i++) s += a[i] * b[i];
    return ACCW'(s);
  endfunction

  // One run: launch, check every cycle up to done, check result, then check
  // the following idle cycle. inj >= 1 injects start plus a write A[0]=9 in
  // that cycle (must lie before done).
  task automatic run(input int l, input bit hold, input int inj, output logic [ACCW-1:0] res);
    int le, dc;
    bit v;
    logic [7:0] sa [DEPTH];
    logic [7:0] sb [DEPTH];
    logic [ACCW-1:0] expr;
    logic [63:0] exp;
    le = (l > DEPTH) ? DEPTH : l;
    dc = (le == 0) ? 1 : le + 3;
    sa = ma; sb = mb;
    expr = dot(sa, sb, le);
    start = 1'b1; len = (AW+1)'(l);
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int c = 1; c <= dc; c++) begin
      if (c > 1) @(negedge clk);
      v = (c >= 2) && (c <= le + 1);
      exp = {44'b0, 1'b1, (c == dc), (le != 0 && c == 1), v,
             v ? sa[c-2] : 8'h00, v ? sb[c-2] : 8'h00};
      check($sformatf("len%0d_cyc%0d", l, c),
            {44'b0, busy, done, mac_clr, mac_vld, mac_a, mac_b}, exp);
      if (c == inj) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'd9;
      end
      if (c == inj + 1) begin
        start = hold; wr_en = 1'b0;
      end
    end
    check($sformatf("len%0d_result", l), 64'(result), 64'(expr));
    res = result;
    @(negedge clk);
    check($sformatf("len%0d_idle", l), {44'b0, busy, done, mac_clr, mac_vld, result},
          {48'b0, expr});
  endtask

  initial begin
    logic [ACCW-1:0] r;
    for (int i = 0; i < DEPTH; i++) begin ma[i] = 8'h00; mb[i] = 8'h00; end

    // ---- Reset state ----
    #3;
    check("reset_outputs", {27'b0, busy, done, mac_clr, mac_vld, mac_a, mac_b, result}, 64'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ---- Basic run ----
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, i, 8'(i + 1));
      wr(1'b1, i, 8'(i + 5));
    end
    run(4, 1'b0, -1, r);
    check("basic_70", 64'(r), 64'd70);

    // ---- Zero length ----
    run(0, 1'b0, -1, r);
    check("zero_len", 64'(r), 64'd0);

    // ---- Wrap and clamp ----
    wr(1'b0, 0, 8'hFF); wr(1'b0, 1, 8'hFF);
    wr(1'b1, 0, 8'hFF); wr(1'b1, 1, 8'hFF);
    run(2, 1'b0, -1, r);
    check("wrap_64514", 64'(r), 64'd64514);
    for (int i = 0; i < DEPTH; i++) begin wr(1'b0, i, 8'd1); wr(1'b1, i, 8'd1); end
    run(16, 1'b0, -1, r);
    check("full_16", 64'(r), 64'd16);
    run(17, 1'b0, -1, r);
    check("clamp_17", 64'(r), 64'd16);

    // ---- Ignored start/write while busy ----
    wr(1'b0, 0, 8'd3); wr(1'b1, 0, 8'd7);
    run(8, 1'b0, 3, r);
    check("ignored_result", 64'(r), 64'd28);
    // A[0] must still be 3 (not 9): re-run and look at the first pair.
    run(1, 1'b0, -1, r);
    check("a0_kept", 64'(r), 64'd21);

    // ---- Back-to-back with start held high ----
    for (int i = 0; i < DEPTH; i++) begin
      wr(1'b0, i, 8'($urandom));
      wr(1'b1, i, 8'($urandom));
    end
    run(5, 1'b1, -1, r);
    run(3, 1'b0, -1, r);

    // ---- Random runs ----
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 3; j++) begin
        wr(1'(j), int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
      end
      run(int'($urandom_range(0, 20)), 1'b0, -1, r);
    end

    // ---- Reset mid-run ----
    start = 1'b1; len = 5'd8;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);          // now in STREAM
    check("pre_reset_stream", {63'b0, mac_vld}, 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_reset_outputs", {27'b0, busy, done, mac_clr, mac_vld, mac_a, mac_b, result}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin ma[i] = 8'h00; mb[i] = 8'h00; end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("post_reset_quiet%0d", c), {62'b0, busy, done}, 64'd0);
    end
    run(5, 1'b0, -1, r);
    check("post_reset_zero", 64'(r), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
